hdmi_pattern_gen: RTL and testbench

//  Parametrised video timing + test-pattern source for the HDMI (ADV7511) output path, on the SI570 pixel clock.

---
 rtl/hdmi_vid_pkg.sv | 24 ++
 rtl/vid_timing_core.sv | 64 ++++++
 rtl/hdmi_pattern_gen.sv | 204 ++++++++++++++++++++
 tb/tb_hdmi_pattern_gen.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_vid_pkg.sv
// Shared constants for the HDMI test-pattern source.
// Mode codes, reference luma levels and the colour-bar table.
package hdmi_vid_pkg;

    localparam logic [3:0] MODE_HRAMP = 4'd0;
    localparam logic [3:0] MODE_VRAMP = 4'd1;
    localparam logic [3:0] MODE_BARS  = 4'd2;
    localparam logic [3:0] MODE_CHECK = 4'd3;
    localparam logic [3:0] MODE_SBOX  = 4'd4;
    localparam logic [3:0] MODE_MBOX  = 4'd5;
    localparam logic [3:0] MODE_FILL  = 4'd6;
    localparam logic [3:0] MODE_FCNT  = 4'd7;

    localparam logic [7:0] Y_BLACK  = 8'h10;
    localparam logic [7:0] Y_WHITE  = 8'hEB;
    localparam logic [7:0] C_NEUTRAL = 8'h80;

    // Bar n luma = 8'hEB - 8'h1E * n
    localparam logic [7:0] BAR_Y [8] = '{
        8'hEB, 8'hCD, 8'hAF, 8'h91,
        8'h73, 8'h55, 8'h37, 8'h19
    };

endpackage

// File: rtl/vid_timing_core.sv
// Video raster counters and timing flags.
// Flags are combinational from the counters; frame_cnt is registered.
module vid_timing_core #(
    parameter int CW       = 12,
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36
) (
    input  logic          clk,
    input  logic          rst,
    output logic [CW-1:0] hcnt,
    output logic [CW-1:0] vcnt,
    output logic [CW-1:0] frame_cnt,
    output logic          active,
    output logic          hs_on,
    output logic          vs_on,
    output logic          frame_end
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] H_LAST = CW'(H_TOT - 1);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOT - 1);

    logic line_end;

    assign line_end  = (hcnt == H_LAST);
    assign frame_end = line_end && (vcnt == V_LAST);
    assign active    = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign hs_on     = (hcnt >= HS_BEG) && (hcnt < HS_END);
    assign vs_on     = (vcnt >= VS_BEG) && (vcnt < VS_END);

    // Raster scan: pixel, line and frame counters
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt      <= '0;
            vcnt      <= '0;
            frame_cnt <= '0;
        end else if (line_end) begin
            hcnt <= '0;
            if (vcnt == V_LAST) begin
                vcnt      <= '0;
                frame_cnt <= frame_cnt + 1'b1;
            end else begin
                vcnt <= vcnt + 1'b1;
            end
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

endmodule

// File: rtl/hdmi_pattern_gen.sv
// Programmable video timing and test-pattern source for the HDMI path.
// Two register stages: pattern/flags, then output flops.
module hdmi_pattern_gen #(
    parameter int DW       = 16,
    parameter int CW       = 12,
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int BOX_SZ   = 128,
    parameter int BOX_STEP = 4
) (
    input  logic          sys2_clk,
    input  logic          sys2_rst,
    input  logic [3:0]    mode,
    input  logic [DW-1:0] fill,
    output logic          vid_de,
    output logic          vid_hs,
    output logic          vid_vs,
    output logic [DW-1:0] vid_data,
    output logic          sof,
    output logic [CW-1:0] frame_cnt
);

    import hdmi_vid_pkg::*;

    localparam int BAR_W = H_ACTIVE / 8;

    localparam logic [CW-1:0] STEP  = CW'(BOX_STEP);
    localparam logic [CW-1:0] X_LIM = CW'(H_ACTIVE - BOX_SZ);
    localparam logic [CW-1:0] Y_LIM = CW'(V_ACTIVE - BOX_SZ);
    localparam logic [CW:0]   SZ    = (CW+1)'(BOX_SZ);
    localparam logic [CW:0]   SB_LO = (CW+1)'(128);

    logic [CW-1:0] hcnt;
    logic [CW-1:0] vcnt;
    logic          active;
    logic          hs_on;
    logic          vs_on;
    logic          frame_end;

    logic [3:0]    mode_r;
    logic [CW-1:0] box_x;
    logic [CW-1:0] box_y;
    logic          dir_x;
    logic          dir_y;
    logic [CW:0]   nx;
    logic [CW:0]   ny;

    logic [2:0]    bar;
    logic          in_sbox;
    logic          in_mbox;
    logic [7:0]    y;
    logic [DW-1:0] pix;

    logic          s1_de;
    logic          s1_hs;
    logic          s1_vs;
    logic          s1_sof;
    logic [DW-1:0] s1_data;

    // Returns {dir, pos}; reaching a limit clamps there and reverses
    function automatic logic [CW:0] bounce(
        input logic [CW-1:0] pos,
        input logic          fwd,
        input logic [CW-1:0] lim
    );
        logic [CW:0] up;
        up = {1'b0, pos} + {1'b0, STEP};
        if (fwd) begin
            if (up >= {1'b0, lim})
                bounce = {1'b0, lim};
            else
                bounce = {1'b1, up[CW-1:0]};
        end else if (pos <= STEP) begin
            bounce = {1'b1, {CW{1'b0}}};
        end else begin
            bounce = {1'b0, pos - STEP};
        end
    endfunction

    function automatic logic [DW-1:0] fmt(input logic [7:0] luma);
        if (DW == 16)
            fmt = DW'({C_NEUTRAL, luma});
        else
            fmt = DW'({luma, luma, luma});
    endfunction

    vid_timing_core #(
        .CW       (CW),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk       (sys2_clk),
        .rst       (sys2_rst),
        .hcnt      (hcnt),
        .vcnt      (vcnt),
        .frame_cnt (frame_cnt),
        .active    (active),
        .hs_on     (hs_on),
        .vs_on     (vs_on),
        .frame_end (frame_end)
    );

    assign nx = bounce(box_x, dir_x, X_LIM);
    assign ny = bounce(box_y, dir_y, Y_LIM);

    // Mode and box position only change at the frame wrap
    always_ff @(posedge sys2_clk) begin
        if (sys2_rst) begin
            mode_r <= MODE_HRAMP;
            box_x  <= '0;
            box_y  <= '0;
            dir_x  <= 1'b1;
            dir_y  <= 1'b1;
        end else if (frame_end) begin
            mode_r         <= mode;
            {dir_x, box_x} <= nx;
            {dir_y, box_y} <= ny;
        end
    end

    assign in_sbox = ({1'b0, hcnt} >= SB_LO) &&
                     ({1'b0, hcnt} <  SB_LO + SZ) &&
                     ({1'b0, vcnt} >= SB_LO) &&
                     ({1'b0, vcnt} <  SB_LO + SZ);

    assign in_mbox = (hcnt >= box_x) &&
                     ({1'b0, hcnt} < {1'b0, box_x} + SZ) &&
                     (vcnt >= box_y) &&
                     ({1'b0, vcnt} < {1'b0, box_y} + SZ);

    // Bar index from the pixel column
    always_comb begin
        bar = '0;
        for (int i = 1; i < 8; i++) begin
            if (hcnt >= CW'(i * BAR_W))
                bar = 3'(i);
        end
    end

    // Pattern select for the current raster position
    always_comb begin
        y = Y_BLACK;
        case (mode_r)
            MODE_HRAMP: y = hcnt[7:0];
            MODE_VRAMP: y = vcnt[7:0];
            MODE_BARS:  y = BAR_Y[bar];
            MODE_CHECK: y = (hcnt[6] ^ vcnt[6]) ? Y_WHITE : Y_BLACK;
            MODE_SBOX:  y = in_sbox ? vcnt[7:0] : hcnt[7:0];
            MODE_MBOX:  y = in_mbox ? frame_cnt[7:0] : hcnt[7:0];
            MODE_FCNT:  y = frame_cnt[7:0];
            default:    y = Y_BLACK;
        endcase
        pix = (mode_r == MODE_FILL) ? fill : fmt(y);
    end

    // Stage 1: timing flags and blanked pixel word
    always_ff @(posedge sys2_clk) begin
        if (sys2_rst) begin
            s1_de   <= 1'b0;
            s1_hs   <= ~HS_POL;
            s1_vs   <= ~VS_POL;
            s1_sof  <= 1'b0;
            s1_data <= '0;
        end else begin
            s1_de   <= active;
            s1_hs   <= hs_on ? HS_POL : ~HS_POL;
            s1_vs   <= vs_on ? VS_POL : ~VS_POL;
            s1_sof  <= (hcnt == '0) && (vcnt == '0);
            s1_data <= active ? pix : '0;
        end
    end

    // Stage 2: output flops feeding the IOB registers
    always_ff @(posedge sys2_clk) begin
        if (sys2_rst) begin
            vid_de   <= 1'b0;
            vid_hs   <= ~HS_POL;
            vid_vs   <= ~VS_POL;
            sof      <= 1'b0;
            vid_data <= '0;
        end else begin
            vid_de   <= s1_de;
            vid_hs   <= s1_hs;
            vid_vs   <= s1_vs;
            sof      <= s1_sof;
            vid_data <= s1_data;
        end
    end

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// Bench for hdmi_pattern_gen: small-raster scoreboard, sync polarity,
// and 1080p-width colour bars.
`timescale 1ns/1ps
module tb_hdmi_pattern_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_run = 0;
    int n_fail = 0;

    // u0: small raster, positive syncs, 24-bit
    logic        rst0 = 1'b1;
    logic [3:0]  mode0 = 4'd0;
    logic [23:0] fill0 = 24'h0;
    logic        de0, hs0, vs0, sof0;
    logic [23:0] data0;
    logic [11:0] fc0;

    hdmi_pattern_gen #(
        .DW(24), .CW(12),
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(4),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .HS_POL(1'b1), .VS_POL(1'b1), .BOX_SZ(4), .BOX_STEP(3)
    ) u0 (
        .sys2_clk(clk), .sys2_rst(rst0), .mode(mode0), .fill(fill0),
        .vid_de(de0), .vid_hs(hs0), .vid_vs(vs0), .vid_data(data0),
        .sof(sof0), .frame_cnt(fc0)
    );

    // u1: small raster, negative syncs, 16-bit
    logic        rst1 = 1'b1;
    logic [3:0]  mode1 = 4'd0;
    logic [15:0] fill1 = 16'h0;
    logic        de1, hs1, vs1, sof1;
    logic [15:0] data1;
    logic [11:0] fc1;

    hdmi_pattern_gen #(
        .DW(16), .CW(12),
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(4),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0), .BOX_SZ(4), .BOX_STEP(3)
    ) u1 (
        .sys2_clk(clk), .sys2_rst(rst1), .mode(mode1), .fill(fill1),
        .vid_de(de1), .vid_hs(hs1), .vid_vs(vs1), .vid_data(data1),
        .sof(sof1), .frame_cnt(fc1)
    );

    // u2: 1080p line timing, short frame, 16-bit
    logic        rst2 = 1'b1;
    logic [3:0]  mode2 = 4'd2;
    logic [15:0] fill2 = 16'h0;
    logic        de2, hs2, vs2, sof2;
    logic [15:0] data2;
    logic [11:0] fc2;

    hdmi_pattern_gen #(
        .DW(16), .CW(12),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u2 (
        .sys2_clk(clk), .sys2_rst(rst2), .mode(mode2), .fill(fill2),
        .vid_de(de2), .vid_hs(hs2), .vid_vs(vs2), .vid_data(data2),
        .sof(sof2), .frame_cnt(fc2)
    );

    // Scoreboard for u0
    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic        sof;
        logic [23:0] data;
    } exp_t;

    exp_t q[$];
    int mh, mv, mframe;
    logic [3:0] mmode;
    int cnt_de, cnt_sof;

    // Box position per completed-frame count (edge 4, step 3, limits 12/4)
    int bx_tab [0:9] = '{0, 3, 6, 9, 12, 9, 6, 3, 0, 3};
    int by_tab [0:9] = '{0, 3, 4, 1, 0, 3, 4, 1, 0, 3};

    function automatic exp_t model_out(int h, int v, int fr,
                                       logic [3:0] md, logic [23:0] fl);
        exp_t e;
        logic [7:0] yy;
        int bx, by;
        e.de  = (h < 16) && (v < 8);
        e.hs  = (h >= 18) && (h < 20);
        e.vs  = (v == 9);
        e.sof = (h == 0) && (v == 0);
        bx = bx_tab[fr % 10];
        by = by_tab[fr % 10];
        case (md)
            4'd0: yy = 8'(h);
            4'd1: yy = 8'(v);
            4'd2: yy = 8'(235 - 30 * (h / 2));
            4'd3: yy = (((h / 64) % 2) != ((v / 64) % 2)) ? 8'hEB : 8'h10;
            4'd4: yy = (h >= 128 && h < 132 && v >= 128 && v < 132)
                       ? 8'(v) : 8'(h);
            4'd5: yy = (h >= bx && h < bx + 4 && v >= by && v < by + 4)
                       ? 8'(fr) : 8'(h);
            4'd7: yy = 8'(fr);
            default: yy = 8'h10;
        endcase
        if (!e.de)
            e.data = 24'h0;
        else if (md == 4'd6)
            e.data = fl;
        else
            e.data = {yy, yy, yy};
        return e;
    endfunction

    task automatic step();
        exp_t e, got;
        q.push_back(model_out(mh, mv, mframe, mmode, fill0));
        @(posedge clk);
        #1;
        if (mh == 23) begin
            mh = 0;
            if (mv == 11) begin
                mv = 0;
                mframe++;
                mmode = mode0;
            end else begin
                mv++;
            end
        end else begin
            mh++;
        end
        e = q.pop_front();
        got = '{de0, hs0, vs0, sof0, data0};
        cnt_de  += int'(de0);
        cnt_sof += int'(sof0);
        n_run++;
        if (got !== e) begin
            n_fail++;
            if (n_fail < 20)
                $display("FAIL pixel h=%0d v=%0d got %h want %h",
                         mh, mv, got, e);
        end
        n_run++;
        if (fc0 !== 12'(mframe)) begin
            n_fail++;
            if (n_fail < 20)
                $display("FAIL frame_cnt got %0d want %0d", fc0, mframe);
        end
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        exp_t got;
        rst0 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        got = '{de0, hs0, vs0, sof0, data0};
        n_run++;
        if (got !== exp_t'(0)) begin
            n_fail++;
            $display("FAIL reset_idle got %h want %h", got, exp_t'(0));
        end
        n_run++;
        if (fc0 !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_fcnt got %0d want 0", fc0);
        end
        mh = 0; mv = 0; mframe = 0; mmode = 4'd0;
        q.delete();
        q.push_back(exp_t'(0));
        rst0 = 1'b0;
    endtask

    task automatic test_timing();
        mode0 = 4'd0;
        test_reset();
        cnt_de = 0; cnt_sof = 0;
        steps(288);
        n_run++;
        if (cnt_de != 128) begin
            n_fail++;
            $display("FAIL de_per_frame got %0d want 128", cnt_de);
        end
        n_run++;
        if (cnt_sof != 1) begin
            n_fail++;
            $display("FAIL sof_per_frame got %0d want 1", cnt_sof);
        end
    endtask

    task automatic test_mode_switch();
        mode0 = 4'd0;
        test_reset();
        cnt_sof = 0;
        steps(100);
        mode0 = 4'd1;
        steps(764);
        n_run++;
        if (cnt_sof != 3) begin
            n_fail++;
            $display("FAIL sof_3_frames got %0d want 3", cnt_sof);
        end
    endtask

    task automatic test_patterns();
        logic [3:0] ml [7] = '{4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8, 4'd15};
        test_reset();
        foreach (ml[i]) begin
            mode0 = ml[i];
            fill0 = 24'($urandom);
            steps(576);
        end
    endtask

    task automatic test_box();
        mode0 = 4'd5;
        test_reset();
        steps(2880);
    endtask

    task automatic test_mid_reset();
        int t;
        exp_t got;
        mode0 = 4'd0;
        test_reset();
        t = 0;
        while (!(mh == 10 && mv == 5) && t < 400) begin
            step();
            t++;
        end
        n_run++;
        if (!(mh == 10 && mv == 5)) begin
            n_fail++;
            $display("FAIL mid_reset_reach got h=%0d v=%0d want 10/5", mh, mv);
        end
        rst0 = 1'b1;
        @(posedge clk);
        #1;
        got = '{de0, hs0, vs0, sof0, data0};
        n_run++;
        if (got !== exp_t'(0)) begin
            n_fail++;
            $display("FAIL mid_reset_idle got %h want %h", got, exp_t'(0));
        end
        n_run++;
        if (fc0 !== 12'd0) begin
            n_fail++;
            $display("FAIL mid_reset_fcnt got %0d want 0", fc0);
        end
        mh = 0; mv = 0; mframe = 0; mmode = 4'd0;
        q.delete();
        q.push_back(exp_t'(0));
        rst0 = 1'b0;
        step();
        n_run++;
        if (de0 !== 1'b0) begin
            n_fail++;
            $display("FAIL de_after_1 got %b want 0", de0);
        end
        step();
        n_run++;
        if (de0 !== 1'b1 || sof0 !== 1'b1) begin
            n_fail++;
            $display("FAIL de_after_2 got %b/%b want 1/1", de0, sof0);
        end
        steps(300);
    endtask

    task automatic test_polarity();
        int nhs, nvs, nde;
        rst1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_run++;
        if (hs1 !== 1'b1 || vs1 !== 1'b1 || de1 !== 1'b0 || data1 !== 16'h0) begin
            n_fail++;
            $display("FAIL neg_idle got hs=%b vs=%b de=%b d=%h want 1 1 0 0",
                     hs1, vs1, de1, data1);
        end
        rst1 = 1'b0;
        nhs = 0; nvs = 0; nde = 0;
        @(posedge clk);
        for (int i = 0; i < 288; i++) begin
            @(posedge clk);
            #1;
            nhs += int'(!hs1);
            nvs += int'(!vs1);
            nde += int'(de1);
            if (i == 0) begin
                n_run++;
                if (data1 !== 16'h8000 || sof1 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL neg_px0 got %h/%b want 8000/1", data1, sof1);
                end
            end
            if (i == 5) begin
                n_run++;
                if (data1 !== 16'h8005) begin
                    n_fail++;
                    $display("FAIL neg_px5 got %h want 8005", data1);
                end
            end
            if (i == 18 || i == 20) begin
                n_run++;
                if (hs1 !== (i == 20)) begin
                    n_fail++;
                    $display("FAIL neg_hs_at_%0d got %b want %b", i, hs1, i == 20);
                end
            end
        end
        n_run++;
        if (nhs != 24 || nvs != 24 || nde != 128) begin
            n_fail++;
            $display("FAIL neg_counts got hs=%0d vs=%0d de=%0d want 24 24 128",
                     nhs, nvs, nde);
        end
    endtask

    task automatic test_bars_1080();
        int seen, t;
        rst2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst2 = 1'b0;
        seen = 0;
        t = 0;
        while (seen < 2 && t < 30000) begin
            @(posedge clk);
            #1;
            t++;
            if (sof2) seen++;
        end
        n_run++;
        if (seen < 2) begin
            n_fail++;
            $display("FAIL bars_sof_timeout got %0d want 2", seen);
        end else begin
            n_run++;
            if (data2 !== 16'h80EB || fc2 !== 12'd1) begin
                n_fail++;
                $display("FAIL bars_px0 got %h fc=%0d want 80eb fc=1", data2, fc2);
            end
            repeat (240) @(posedge clk);
            #1;
            n_run++;
            if (data2 !== 16'h80CD) begin
                n_fail++;
                $display("FAIL bars_px240 got %h want 80cd", data2);
            end
            repeat (1679) @(posedge clk);
            #1;
            n_run++;
            if (data2 !== 16'h8019 || de2 !== 1'b1) begin
                n_fail++;
                $display("FAIL bars_px1919 got %h/%b want 8019/1", data2, de2);
            end
            @(posedge clk);
            #1;
            n_run++;
            if (data2 !== 16'h0 || de2 !== 1'b0) begin
                n_fail++;
                $display("FAIL bars_blank got %h/%b want 0/0", data2, de2);
            end
        end
    endtask

    initial begin
        test_timing();
        test_mode_switch();
        test_patterns();
        test_box();
        test_mid_reset();
        test_polarity();
        test_bars_1080();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
